fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end. Produces the instruction word and PC that the decode/control stage consumes.
- Owns the PC register and drives the icache request handshake (iREN/iaddr, returning ihit/iload).
- Holds one fetched word in an output slot under downstream stall.
- Applies jump/branch redirects and stops fetching when the decode stage flags HALT.
- One instance per core.

Parameters:
- PC_INIT, 32'h0000_0000, PC loaded on reset (core 1 is instantiated with 32'h0000_0200).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous assert; active-high.
- iREN  out  1  icache read request.
- iaddr  out  32  icache read address; always equals pc.
- ihit  in  1  icache data valid; honoured only in a cycle where iREN=1.
- iload  in  32  icache read data.
- stall  in  1  downstream cannot accept the slot this cycle.
- redirect_valid  in  1  taken jump/branch resolved.
- redirect_pc  in  32  redirect target; word aligned.
- halt_dec  in  1  the decoder reports that the current Instr is HALT.
- Instr  out  32  slot instruction to decoder.
- instr_valid  out  1  slot holds a valid instruction.
- pc  out  32  fetch PC.
- instr_pc  out  32  PC of the slot instruction.
- npc  out  32  instr_pc + 4, used by the JAL link path.
- halted  out  1  fetch stopped.
- fetch_cnt  out  32  statistics counter (see Optional Feature).
- stall_cnt  out  32  statistics counter (see Optional Feature).

Behaviour:
- Reset values:
  - pc=PC_INIT.
  - Instr=0, instr_valid=0, instr_pc=0, halted=0.
  - Counters 0.
  - State BOOT.
- States:
  - BOOT: iREN=0 for exactly one cycle, then RUN.
  - RUN: normal fetching.
  - HALTED: iREN=0, instr_valid=0, halted=1. Exit only via reset.
- RUN request rule: iREN = !redirect_valid && (!instr_valid || !stall). iaddr = pc combinationally.
- consume = instr_valid && !stall.
- Accept: iREN && ihit at an edge gives Instr<=iload, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
  - Latency: 1 cycle from ihit to instr_valid.
  - Back-to-back hits yield one instruction per cycle.
- Consume without accept gives instr_valid<=0.
- Stall with a valid slot: Instr, instr_pc and instr_valid hold. iREN=0, so any ihit that cycle is ignored and pc is unchanged.
- Redirect has priority over everything except reset and HALTED:
  - pc<=redirect_pc and instr_valid<=0 at the same edge.
  - iREN=0 that cycle; any concurrent ihit is discarded.
  - Fetch resumes from redirect_pc the next cycle.
  - Redirect together with stall still squashes.
- Halt: instr_valid && halt_dec && !stall && !redirect_valid at an edge gives HALTED, instr_valid<=0, pc frozen. Words arriving that cycle are discarded.
- PC arithmetic: 32-bit; pc+4 wraps 32'hFFFF_FFFC to 0 silently. pc[1:0] is always 0.
- Reset mid-request: immediate return to reset values, with iREN=0 combinationally while RST=1.
- npc = instr_pc + 4 at all times.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - fetch_cnt increments on every accept.
  - stall_cnt increments each RUN cycle with instr_valid && stall.
  - Both are 32-bit, wrap at 2^32, cleared by reset, and frozen in HALTED.
- Undefined: fetch_cnt and stall_cnt are tied to 0 and no counter flops exist.

Decomposition:
- cpu_types_pkg gains:
  - word_t (reused).
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - PC_STEP constant = 4.
- Sub-module fetch_slot:
  - Slot register holding Instr, instr_pc and instr_valid.
  - Load/hold/clear inputs.
  - Keeps the FSM/PC logic in fetch_unit.

Test Plan:
1. Reset with PC_INIT=0x200, then ihit=1 every cycle with iload = address-derived words → iREN low in the BOOT cycle. Instr sequence for 0x200, 0x204, 0x208 on consecutive cycles; instr_valid continuous.
2. Slot holding 0x3C010001 with stall=1 for 3 cycles and ihit=1 → Instr, instr_pc and pc unchanged; iREN=0; after stall drops, the next word for pc+4 arrives 1 cycle later.
3. redirect_valid=1 with redirect_pc=0x40 in the same cycle as ihit for 0x10 → word discarded; instr_valid=0 next cycle; iaddr=0x40; the next accepted Instr has instr_pc=0x40.
4. HALT word 0xFFFFFFFF in the slot with halt_dec=1 and stall=0 → halted=1 next cycle; iREN stays 0 for 20 cycles; pc frozen.
5. Assert RST mid-stall with a valid slot → outputs are reset values within the same cycle; recovery fetches from PC_INIT.
6. With FETCH_STATS_EN defined, 5 accepts and 2 stalled cycles → fetch_cnt=5, stall_cnt=2. Without the macro, both read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU types: machine word, fetch FSM states, PC step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_slot.sv
// ============================================================================
//  Module      : fetch_slot
//  Description : One-entry instruction slot (word, PC, valid) with load/clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        valid
);

    // Clear wins over load; with neither asserted the slot holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            instr_pc <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= load_instr;
            instr_pc <= load_pc;
            valid    <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end: PC, icache request, output slot,
//                redirect and HALT handling. Statistics counters are built
//                only when FETCH_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_dec,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] instr_pc,
    output logic [31:0] npc,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         fetch_req;
    logic         redirect_take;
    logic         halt_take;
    logic         accept;
    logic         consume;
    logic         slot_clear;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fetch_req     = 1'b0;
        redirect_take = 1'b0;
        halt_take     = 1'b0;
        case (state)
            BOOT: begin
                state_nxt     = RUN;
                redirect_take = redirect_valid;
            end
            RUN: begin
                redirect_take = redirect_valid;
                fetch_req     = !redirect_valid && (!instr_valid || !stall);
                halt_take     = !redirect_valid && instr_valid && halt_dec && !stall;
                if (halt_take) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // A word returning in the HALT cycle is dropped even though iREN was high.
    assign iREN       = fetch_req && !RST;
    assign accept     = fetch_req && ihit && !halt_take;
    assign consume    = instr_valid && !stall;
    assign slot_clear = redirect_take || halt_take || (consume && !accept);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= PC_INIT;
        end else if (redirect_take) begin
            pc <= redirect_pc & ~(PC_STEP - 32'd1);
        end else if (accept) begin
            pc <= pc + PC_STEP;
        end
    end

    fetch_slot u_slot (
        .clk        (CLK),
        .rst        (RST),
        .load       (accept),
        .clear      (slot_clear),
        .load_instr (iload),
        .load_pc    (pc),
        .instr      (Instr),
        .instr_pc   (instr_pc),
        .valid      (instr_valid)
    );

    assign iaddr  = pc;
    assign npc    = instr_pc + PC_STEP;
    assign halted = (state == HALTED);

`ifdef FETCH_STATS_EN
    word_t fetch_cnt_q;
    word_t stall_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state == RUN) && instr_valid && stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
